// File: rtl/exp4_pkg.sv
// State encodings shared by the control unit, the datapath and the top-level debug display.
// Pure declarations: no latency and no backpressure.
package exp4_pkg;

  typedef enum logic [3:0] {
    ST_INICIAL     = 4'h0,
    ST_PREPARACAO  = 4'h1,
    ST_ESPERA      = 4'h2,
    ST_REGISTRA    = 4'h4,
    ST_COMPARA     = 4'h5,
    ST_PROXIMO     = 4'h6,
    ST_FIM_ACERTO  = 4'hA,
    ST_FIM_TIMEOUT = 4'hD,
    ST_FIM_ERRO    = 4'hE
  } estado_t;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 5000;

  // The three terminal states all accept a restart request.
  function automatic logic is_fim(input estado_t e);
    return (e == ST_FIM_ACERTO) || (e == ST_FIM_ERRO) || (e == ST_FIM_TIMEOUT);
  endfunction

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector: pulso is high for the one cycle where sinal is high and was low.
// Latency: combinational against a 1-flop history; no backpressure, a held level yields one pulse.
module edge_detector (
  input  logic clock,
  input  logic reset,
  input  logic sinal,
  output logic pulso
);

  logic sinal_prev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sinal_prev <= 1'b0;
    end else begin
      sinal_prev <= sinal;
    end
  end

  assign pulso = sinal & ~sinal_prev;

endmodule

// File: rtl/exp4_unidade_controle.sv
// Moore control FSM for the play-check datapath; EXP4_TIMEOUT_EN adds a per-play ESPERA timeout.
// Latency: result visible 3 cycles after a jogada press; no backpressure, presses outside ESPERA are dropped.
module exp4_unidade_controle
  import exp4_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  estado_t estado;
  estado_t proximo;
  logic    jogada_pulso;
  logic    expirou;

  edge_detector u_jogada_edge (
    .clock (clock),
    .reset (reset),
    .sinal (jogada),
    .pulso (jogada_pulso)
  );

`ifdef EXP4_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_ULTIMO = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_espera;

  // Cleared outside ESPERA, so every entry into ESPERA starts a fresh budget.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_espera <= '0;
    end else if (estado == ST_ESPERA) begin
      cnt_espera <= cnt_espera + 1'b1;
    end else begin
      cnt_espera <= '0;
    end
  end

  assign expirou = (estado == ST_ESPERA) && (cnt_espera == CNT_ULTIMO);
`else
  assign expirou = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= ST_INICIAL;
    end else begin
      estado <= proximo;
    end
  end

  always_comb begin
    proximo   = estado;
    zeraC     = 1'b0;
    contaC    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    pronto    = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    timeout   = 1'b0;
    db_estado = estado;

    case (estado)
      ST_INICIAL: begin
        if (iniciar) proximo = ST_PREPARACAO;
      end
      ST_PREPARACAO: begin
        zeraC   = 1'b1;
        zeraR   = 1'b1;
        proximo = ST_ESPERA;
      end
      ST_ESPERA: begin
        // A press on the expiry cycle still counts as a play.
        if (jogada_pulso) begin
          proximo = ST_REGISTRA;
        end else if (expirou) begin
          proximo = ST_FIM_TIMEOUT;
        end
      end
      ST_REGISTRA: begin
        registraR = 1'b1;
        proximo   = ST_COMPARA;
      end
      ST_COMPARA: begin
        if (!igual) begin
          proximo = ST_FIM_ERRO;
        end else if (fimC) begin
          proximo = ST_FIM_ACERTO;
        end else begin
          proximo = ST_PROXIMO;
        end
      end
      ST_PROXIMO: begin
        contaC  = 1'b1;
        proximo = ST_ESPERA;
      end
      ST_FIM_ACERTO: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      ST_FIM_ERRO: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      ST_FIM_TIMEOUT: begin
        pronto = 1'b1;
`ifdef EXP4_TIMEOUT_EN
        timeout = 1'b1;
`endif
      end
      default: begin
        proximo = ST_INICIAL;
      end
    endcase

    if (is_fim(estado) && iniciar) proximo = ST_PREPARACAO;
  end

endmodule

// File: tb/tb_exp4_unidade_controle.sv
// Scoreboard bench for exp4_unidade_controle: the bench plays the datapath and a round-level model.
// Build with EXP4_TIMEOUT_EN defined to also exercise the ESPERA timeout with TIMEOUT_CYCLES=8.
module tb_exp4_unidade_controle;

`ifdef EXP4_TIMEOUT_EN
  localparam int TO_CYC = 8;
  localparam bit TO_EN  = 1'b1;
`else
  localparam int TO_CYC = 5000;
  localparam bit TO_EN  = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset, iniciar, jogada, igual, fimC;
  logic       zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  exp4_unidade_controle #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .jogada    (jogada),
    .igual     (igual),
    .fimC      (fimC),
    .zeraC     (zeraC),
    .contaC    (contaC),
    .zeraR     (zeraR),
    .registraR (registraR),
    .pronto    (pronto),
    .acertou   (acertou),
    .errou     (errou),
    .timeout   (timeout),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  // Round phases of the reference model.
  typedef enum int {M_IDLE, M_SETUP, M_WAIT, M_LATCH, M_CHECK, M_STEP, M_WON, M_LOST, M_SLOW} phase_t;

  phase_t      ph;
  int          waited;
  bit          jprev;
  logic [3:0]  addr;
  logic [7:0]  sw_reg;
  logic [7:0]  chaves;
  logic [7:0]  mem [16];
  logic [11:0] exp_q [$];
  logic [11:0] e_vec, a_vec;
  int          total = 0;
  int          bad   = 0;
  int          n_zera = 0, n_conta = 0, n_reg = 0;
  int          c0;
  bit          cur_jog;

  // Expected {db_estado, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}.
  function automatic logic [11:0] expect_of(input phase_t p);
    case (p)
      M_IDLE:  return {4'h0, 8'b0000_0000};
      M_SETUP: return {4'h1, 8'b1010_0000};
      M_WAIT:  return {4'h2, 8'b0000_0000};
      M_LATCH: return {4'h4, 8'b0001_0000};
      M_CHECK: return {4'h5, 8'b0000_0000};
      M_STEP:  return {4'h6, 8'b0100_0000};
      M_WON:   return {4'hA, 8'b0000_1100};
      M_LOST:  return {4'hE, 8'b0000_1010};
      M_SLOW:  return {4'hD, 8'b0000_1001};
      default: return 12'hFFF;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit press;
    if (!reset) begin
      ph    = M_IDLE;
      jprev = 1'b0;
      return;
    end
    press = jogada && !jprev;
    jprev = jogada;
    case (ph)
      M_SETUP: begin addr = 4'd0; sw_reg = 8'd0; end
      M_LATCH: sw_reg = chaves;
      M_STEP:  addr = addr + 4'd1;
      default: ;
    endcase
    case (ph)
      M_IDLE, M_WON, M_LOST, M_SLOW: if (iniciar) ph = M_SETUP;
      M_SETUP: begin ph = M_WAIT; waited = 0; end
      M_WAIT: begin
        waited++;
        if (press) ph = M_LATCH;
        else if (TO_EN && waited == TO_CYC) ph = M_SLOW;
      end
      M_LATCH: ph = M_CHECK;
      M_CHECK: ph = !igual ? M_LOST : (fimC ? M_WON : M_STEP);
      M_STEP:  begin ph = M_WAIT; waited = 0; end
      default: ph = M_IDLE;
    endcase
  endtask

  // One clock: model the edge, drive new inputs 1 ns later, queue the expected outputs.
  task automatic tick(input bit rst_v, input bit ini_v, input bit jog_v, input logic [7:0] sw_v);
    @(posedge clock);
    model_edge();
    #1;
    reset   = rst_v;
    iniciar = ini_v;
    jogada  = jog_v;
    cur_jog = jog_v;
    chaves  = sw_v;
    if (!reset) begin
      ph    = M_IDLE;
      jprev = 1'b0;
    end
    igual = (sw_reg == mem[addr]);
    fimC  = (addr == 4'd15);
    exp_q.push_back(expect_of(ph));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, chaves);
  endtask

  task automatic press(input bit good, input int hold, input int gap);
    logic [7:0] sw;
    sw = good ? mem[addr] : (mem[addr] ^ 8'h5A);
    for (int i = 0; i < hold; i++) tick(1'b1, 1'b0, 1'b1, sw);
    for (int i = 0; i < gap; i++)  tick(1'b1, 1'b0, 1'b0, sw);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, want, $time);
    end
  endtask

  // Monitor: every sampled cycle is a presented output vector compared against the queue.
  initial begin
    forever begin
      @(negedge clock);
      if (zeraC)     n_zera++;
      if (contaC)    n_conta++;
      if (registraR) n_reg++;
      if (exp_q.size() > 0) begin
        e_vec = exp_q.pop_front();
        a_vec = {db_estado, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout};
        total++;
        if (a_vec !== e_vec) begin
          bad++;
          $display("FAIL scoreboard: got %h, want %h at %0t", a_vec, e_vec, $time);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    reset = 1'b0; iniciar = 1'b1; jogada = 1'b0; chaves = 8'd0;
    igual = 1'b0; fimC = 1'b0; cur_jog = 1'b0;
    ph = M_IDLE; jprev = 1'b0; waited = 0; addr = 4'd0; sw_reg = 8'd0;

    // Reset held with iniciar high, then release and start.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 8'd0);
    c0 = n_zera;
    tick(1'b1, 1'b1, 1'b0, 8'd0);
    tick(1'b1, 1'b0, 1'b0, 8'd0);
    idle(3);
    check("zera_pulse_len", n_zera - c0, 1);

    // Full winning round.
    c0 = n_conta;
    for (int i = 0; i < 16; i++) press(1'b1, 1, 4);
    check("conta_pulses", n_conta - c0, 15);
    @(negedge clock);
    check("won_flags", {db_estado, pronto, acertou}, {4'hA, 2'b11});

    // Miss on the third press, then restart without reset.
    tick(1'b1, 1'b1, 1'b0, chaves);
    tick(1'b1, 1'b0, 1'b0, chaves);
    press(1'b1, 1, 4);
    press(1'b1, 1, 4);
    press(1'b0, 1, 4);
    @(negedge clock);
    check("lost_flags", {db_estado, errou, acertou}, {4'hE, 2'b10});
    tick(1'b1, 1'b1, 1'b0, chaves);
    tick(1'b1, 1'b0, 1'b0, chaves);
    @(negedge clock);
    check("restart_state", db_estado, 4'h1);
    tick(1'b1, 1'b0, 1'b0, chaves);

    // Button held for 50 cycles counts once.
    c0 = n_reg;
    press(1'b1, 50, 5);
    check("held_button_reg", n_reg - c0, 1);

`ifdef EXP4_TIMEOUT_EN
    idle(12);
    @(negedge clock);
    check("timeout_flags", {db_estado, pronto, timeout}, {4'hD, 2'b11});
    tick(1'b1, 1'b1, 1'b0, chaves);
    tick(1'b1, 1'b0, 1'b0, chaves);
    tick(1'b1, 1'b0, 1'b0, chaves);
    idle(6);
    tick(1'b1, 1'b0, 1'b1, mem[addr]);
    tick(1'b1, 1'b0, 1'b0, mem[addr]);
    @(negedge clock);
    check("press_on_expiry", {db_estado, registraR}, {4'h4, 1'b1});
    idle(4);
`else
    idle(100);
    @(negedge clock);
    check("wait_forever", {db_estado, timeout}, {4'h2, 1'b0});
`endif

    // Reset asserted while comparing.
    tick(1'b0, 1'b0, 1'b0, chaves);
    tick(1'b1, 1'b1, 1'b0, chaves);
    tick(1'b1, 1'b0, 1'b0, chaves);
    tick(1'b1, 1'b0, 1'b0, chaves);
    tick(1'b1, 1'b0, 1'b1, mem[addr]);
    tick(1'b1, 1'b0, 1'b0, chaves);
    tick(1'b0, 1'b0, 1'b0, chaves);
    @(negedge clock);
    check("async_reset_outputs",
          {db_estado, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}, 12'h000);
    tick(1'b1, 1'b1, 1'b0, chaves);
    tick(1'b1, 1'b0, 1'b0, chaves);
    for (int i = 0; i < 5; i++) press(1'b1, 1 + (i % 3), 4);
    press(1'b0, 1, 4);
    @(negedge clock);
    check("clean_round_after_reset", {db_estado, errou}, {4'hE, 1'b1});

    // Randomised traffic against the model.
    for (int r = 0; r < 1500; r++) begin
      bit         ini_v, jog_v, rst_v;
      logic [7:0] sw_v;
      ini_v = ($urandom % 12 == 0);
      jog_v = ($urandom % 3 == 0) ? ~cur_jog : cur_jog;
      sw_v  = ($urandom % 10 == 0) ? 8'($urandom) : mem[addr];
      rst_v = ($urandom % 300 != 0);
      tick(rst_v, ini_v, jog_v, sw_v);
    end

    repeat (3) @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
